// File: rtl/mem_bus_arbiter_pkg.sv
// Shared state encoding for the unified memory-port arbiter.
// Visible to the core and the debug view alike.
package Mem_Arbiter_enum;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_WAIT,
    ARB_RESP
  } arb_state_t;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_bus_arbiter_rr.sv
// Two-way round-robin pick: on a tie the master
// not granted last wins.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       winner,
  output logic       any_req
);

  always_comb begin
    any_req = |req;
    winner  = 1'b0;
    unique case (1'b1)
      (req == 2'b11): winner = ~last_grant;
      (req == 2'b10): winner = 1'b1;
      default:        winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter and sequencer for the single
// unified memory port; one access outstanding at a time.
module mem_bus_arbiter
  import Mem_Arbiter_enum::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m0_gnt,
  output logic                  m1_gnt,
  output logic                  m0_rvalid,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output arb_state_t            state_o
);

  if (RD_LATENCY < 1 || RD_LATENCY > 15) begin : g_bad_lat
    $error("RD_LATENCY must be in 1..15");
  end

  localparam logic [CNT_W-1:0] LAT = CNT_W'(RD_LATENCY);

  arb_state_t            state;
  arb_state_t            state_n;
  logic                  owner;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [CNT_W-1:0]      cnt;
  logic                  last_grant;
  logic                  winner;
  logic                  any_req;

  rr_arbiter_2 u_rr (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant),
    .winner     (winner),
    .any_req    (any_req)
  );

  always_comb begin
    state_n   = state;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (any_req) state_n = ARB_ACCESS;
      end
      ARB_ACCESS: begin
        mem_write = we_q;
        mem_read  = ~we_q;
        state_n   = we_q ? ARB_IDLE : ARB_WAIT;
      end
      ARB_WAIT: begin
        if (cnt == 4'd1) state_n = ARB_RESP;
      end
      ARB_RESP: begin
        state_n = ARB_IDLE;
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      owner      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cnt        <= '0;
      last_grant <= 1'b1;
    end else begin
      state <= state_n;
      unique case (state)
        ARB_IDLE: begin
          if (any_req) begin
            owner      <= winner;
            last_grant <= winner;
            we_q       <= winner ? m1_we : m0_we;
            addr_q     <= winner ? m1_addr : m0_addr;
            wdata_q    <= winner ? m1_wdata : m0_wdata;
          end
        end
        ARB_ACCESS: begin
          if (!we_q) cnt <= LAT;
        end
        ARB_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) rdata_q <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Address and data stay on the latches; strobes qualify.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign state_o   = state;

  assign m0_gnt    = (state == ARB_ACCESS) && !owner;
  assign m1_gnt    = (state == ARB_ACCESS) &&  owner;
  assign m0_rvalid = (state == ARB_RESP) && !owner;
  assign m1_rvalid = (state == ARB_RESP) &&  owner;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: one DUT at
// read latency 1 with a memory model, one at latency 3.
module tb_mem_bus_arbiter;
  import Mem_Arbiter_enum::*;

  typedef struct {
    logic        own;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } gexp_t;

  typedef struct {
    logic        own;
    logic [31:0] data;
    int          cyc;
  } rexp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  arb_state_t  state_o;

  logic        b_req, b_we;
  logic [31:0] b_addr, b_wdata;
  logic        b_gnt, b_gnt1, b_rvalid, b_rvalid1;
  logic [31:0] b_rdata;
  logic        b_mem_read, b_mem_write;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  arb_state_t  b_state;

  logic [31:0] mem [64];
  gexp_t gq[$];
  rexp_t rq[$];
  gexp_t g;
  rexp_t r;

  assign mem_rdata   = mem[mem_addr[7:2]];
  assign b_mem_rdata = 32'hA000_0000 | 32'(cyc);

  mem_bus_arbiter #(.RD_LATENCY(1)) u1 (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .rdata(rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .state_o(state_o)
  );

  mem_bus_arbiter #(.RD_LATENCY(3)) u3 (
    .clk(clk), .rst(rst),
    .m0_req(b_req), .m0_we(b_we),
    .m0_addr(b_addr), .m0_wdata(b_wdata),
    .m1_req(1'b0), .m1_we(1'b0),
    .m1_addr(32'h0), .m1_wdata(32'h0),
    .m0_gnt(b_gnt), .m1_gnt(b_gnt1),
    .m0_rvalid(b_rvalid), .m1_rvalid(b_rvalid1),
    .rdata(b_rdata),
    .mem_read(b_mem_read), .mem_write(b_mem_write),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .state_o(b_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Grant and response scoreboard for u1.
  always @(negedge clk) begin
    if (rst) begin
      if (m0_gnt || m1_gnt) begin
        chk("gnt_onehot", 64'(m0_gnt & m1_gnt), 0);
        if (gq.size() == 0) begin
          chk("gnt_unexp", 1, 0);
        end else begin
          g = gq.pop_front();
          chk("gnt_owner", 64'(m1_gnt), 64'(g.own));
          chk("gnt_write", 64'(mem_write), 64'(g.we));
          chk("gnt_read", 64'(mem_read), 64'(!g.we));
          chk("gnt_addr", 64'(mem_addr), 64'(g.addr));
          if (g.we) begin
            chk("gnt_wdata", 64'(mem_wdata), 64'(g.wdata));
            mem[g.addr[7:2]] = g.wdata;
          end else begin
            rq.push_back('{own: g.own,
                           data: mem[g.addr[7:2]],
                           cyc: cyc + 2});
          end
        end
      end else if (mem_read || mem_write) begin
        chk("strobe_no_gnt", 1, 0);
      end
      if (m0_rvalid || m1_rvalid) begin
        if (rq.size() == 0) begin
          chk("rvalid_unexp", 1, 0);
        end else begin
          r = rq.pop_front();
          chk("rv_owner", 64'(m1_rvalid), 64'(r.own));
          chk("rv_both", 64'(m0_rvalid & m1_rvalid), 0);
          chk("rv_rdata", 64'(rdata), 64'(r.data));
          chk("rv_cycle", 64'(cyc), 64'(r.cyc));
        end
      end
    end
  end

  task automatic wait_gnt(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m0_gnt || m1_gnt) && n < 20);
  endtask

  task automatic wait_rv(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m0_rvalid || m1_rvalid) && n < 40);
  endtask

  // Caller sits at a negedge with u1 idle.
  task automatic xfer(input logic m, input logic we,
                      input logic [31:0] addr,
                      input logic [31:0] wdata);
    int n;
    gq.push_back('{own: m, we: we,
                   addr: addr, wdata: wdata});
    if (m) begin
      m1_req = 1'b1; m1_we = we;
      m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = 1'b1; m0_we = we;
      m0_addr = addr; m0_wdata = wdata;
    end
    wait_gnt(n);
    chk("gnt_latency", 64'(n), 1);
    m0_req = 1'b0;
    m1_req = 1'b0;
    m0_addr = 32'hFFFF_FFFC;
    m1_addr = 32'hFFFF_FFFC;
    if (we) begin
      @(negedge clk);
      chk("wr_idle", 64'(state_o), 64'(ARB_IDLE));
    end else begin
      wait_rv(n);
      chk("rv_latency", 64'(n), 2);
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    int gc;
    int last_c;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'hDEAD_BEEF;
    rst = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0;
    m0_addr = 32'h10; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0;
    m1_addr = 32'h0; m1_wdata = 32'h0;
    b_req = 1'b0; b_we = 1'b0;
    b_addr = 32'h0; b_wdata = 32'h0;
    gq.push_back('{own: 1'b0, we: 1'b0,
                   addr: 32'h10, wdata: 32'h0});

    // Reset held with m0 requesting.
    repeat (3) begin
      @(negedge clk);
      chk("rst_gnt", 64'({m0_gnt, m1_gnt}), 0);
      chk("rst_rvalid", 64'({m0_rvalid, m1_rvalid}), 0);
      chk("rst_strobe", 64'({mem_read, mem_write}), 0);
      chk("rst_state", 64'(state_o), 64'(ARB_IDLE));
    end
    chk("rst_rdata", 64'(rdata), 0);
    chk("rst_addr", 64'(mem_addr), 0);
    chk("rst_wdata", 64'(mem_wdata), 0);

    @(posedge clk);
    #1 rst = 1'b1;
    wait_gnt(n);
    chk("rst_release_gnt", 64'(n), 2);
    m0_req = 1'b0;
    wait_rv(n);
    chk("first_rd_rvalid", 64'(n), 2);
    @(negedge clk);

    xfer(1'b1, 1'b1, 32'h40, 32'h1234_5678);
    xfer(1'b0, 1'b0, 32'h40, 32'h0);

    // Latency-3 instance: capture follows cycle counter.
    b_req = 1'b1; b_addr = 32'h20;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b_gnt && n < 20);
    chk("lat3_gnt", 64'(n), 1);
    chk("lat3_read", 64'(b_mem_read), 1);
    chk("lat3_addr", 64'(b_mem_addr), 32'h20);
    gc = cyc;
    b_req = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b_rvalid && n < 40);
    chk("lat3_rvalid", 64'(n), 4);
    chk("lat3_rdata", 64'(b_rdata),
        64'(32'hA000_0000 | 32'(gc + 3)));
    @(negedge clk);

    // Reset while u1 waits on a read.
    gq.push_back('{own: 1'b1, we: 1'b0,
                   addr: 32'h40, wdata: 32'h0});
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h40;
    wait_gnt(n);
    chk("abort_gnt", 64'(n), 1);
    m1_req = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_in_wait", 64'(state_o), 64'(ARB_WAIT));
    rst = 1'b0;
    rq.delete();
    repeat (3) begin
      @(negedge clk);
      chk("abort_rvalid", 64'({m0_rvalid, m1_rvalid}), 0);
      chk("abort_state", 64'(state_o), 64'(ARB_IDLE));
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    mem[16] = 32'hCAFE_F00D;
    xfer(1'b1, 1'b0, 32'h40, 32'h0);

    // Contention: both hold req; grants must alternate.
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0)
        gq.push_back('{own: 1'b0, we: 1'b1,
                       addr: 32'h80, wdata: 32'hAAAA_0000});
      else
        gq.push_back('{own: 1'b1, we: 1'b1,
                       addr: 32'h84, wdata: 32'hBBBB_0000});
    end
    m0_req = 1'b1; m0_we = 1'b1;
    m0_addr = 32'h80; m0_wdata = 32'hAAAA_0000;
    m1_req = 1'b1; m1_we = 1'b1;
    m1_addr = 32'h84; m1_wdata = 32'hBBBB_0000;
    last_c = -1;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(n);
      if (k == 0) chk("cont_first_lat", 64'(n), 1);
      else chk("cont_gap", 64'(cyc - last_c), 2);
      last_c = cyc;
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    repeat (2) @(negedge clk);
    xfer(1'b1, 1'b0, 32'h84, 32'h0);
    xfer(1'b0, 1'b0, 32'h80, 32'h0);

    repeat (3) @(negedge clk);
    chk("gq_drained", 64'(gq.size()), 0);
    chk("rq_drained", 64'(rq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter and sequencer for the single unified memory port of the multicycle RISC-V core. Master 0 is the core's load/store/fetch path; master 1 is the program loader/debug port. Requests are granted round-robin; the block drives one memory access at a time and waits a fixed read latency. It returns read data to the owning master with a one-cycle valid pulse.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, address width
- RD_LATENCY, 1, cycles from mem_read assertion to valid mem_rdata; legal range 1..15

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- m0_req / m1_req  input  1  access request
- m0_we / m1_we  input  1  1 = write, 0 = read
- m0_addr / m1_addr  input  ADDR_WIDTH  byte address
- m0_wdata / m1_wdata  input  DATA_WIDTH  write data
- m0_gnt / m1_gnt  output  1  one-cycle pulse; request accepted and issued to memory
- m0_rvalid / m1_rvalid  output  1  one-cycle pulse; rdata valid for this master
- rdata  output  DATA_WIDTH  last captured read data, shared by both masters
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- mem_addr  output  ADDR_WIDTH  memory address
- mem_wdata  output  DATA_WIDTH  memory write data
- mem_rdata  input  DATA_WIDTH  memory read data
- state_o  output  arb_state_t  debug view of the FSM state

## Operation
- FSM states: ARB_IDLE, ARB_ACCESS, ARB_WAIT, ARB_RESP.
- ARB_IDLE: when any req = 1, choose the winner. Latch owner, addr, wdata and we from the winner. Go to ARB_ACCESS. With no req, stay in ARB_IDLE.
- Winner selection: only one request → that master. Both requests → the master not granted last. last_grant updates on every grant.
- ARB_ACCESS (exactly one cycle): pulse gnt[owner]. Drive mem_addr/mem_wdata from the latched values. Assert mem_write if we, otherwise mem_read.
  - Write → ARB_IDLE.
  - Read → ARB_WAIT with counter loaded to RD_LATENCY.
- ARB_WAIT: decrement counter each cycle. In the cycle where counter = 1, capture mem_rdata into rdata and go to ARB_RESP.
- ARB_RESP (one cycle): pulse rvalid[owner]. rdata holds until the next read capture. Go to ARB_IDLE.
- Master rule: deassert req in the cycle after gnt. req is sampled only in ARB_IDLE; req = 1 seen in ARB_IDLE is a new request.
- Master inputs may change freely after gnt, because all issued values come from latches.
- mem_addr and mem_wdata hold their latched values outside ARB_ACCESS. Only the strobes qualify an access.
- Never more than one access outstanding. A request arriving during ARB_ACCESS, ARB_WAIT or ARB_RESP waits for ARB_IDLE.

## Timing
- Reset values (asserted asynchronously): state ARB_IDLE; all gnt, rvalid, mem_read and mem_write = 0; rdata, mem_addr, mem_wdata = 0; counter 0; last_grant = 1, so m0 wins the first tie.
- Reset mid-access aborts the access. No rvalid is produced for it.
- Request seen in ARB_IDLE at cycle T:
  - gnt and memory strobe at T+1.
  - Write: back in ARB_IDLE at T+2. Next gnt earliest T+3.
  - Read: mem_rdata sampled at the end of cycle T+1+RD_LATENCY; rvalid at T+2+RD_LATENCY. With RD_LATENCY = 1: rvalid at T+3, next gnt earliest T+5.
- Simultaneous requests: one grant per arbitration. The loser keeps req high and is granted in the next ARB_IDLE arbitration.
- A master re-asserting immediately cannot starve the other; grants alternate while both request.
- Counter is 4 bits wide. RD_LATENCY outside 1..15 is a static elaboration error.

## Structure
- Shared package Mem_Arbiter_enum holds arb_state_t (ARB_IDLE, ARB_ACCESS, ARB_WAIT, ARB_RESP). It sits alongside Control_Unit_enum.
- Sub-module rr_arbiter_2: combinational two-way round-robin pick.
  - Inputs: req[1:0], last_grant.
  - Outputs: winner index, any_req.
  - The FSM, latches and counter stay in mem_bus_arbiter.

## Test plan
- Reset: rst = 0 with m0_req = 1 → all strobes/gnt/rvalid = 0, state_o = ARB_IDLE. Release → m0_gnt pulse 2 cycles later.
- Single read, RD_LATENCY = 1: m0 reads 0x0000_0010, memory returns 0xDEAD_BEEF → mem_read at T+1 with mem_addr = 0x10; m0_rvalid at T+3 with rdata = 0xDEAD_BEEF; m1_rvalid stays 0.
- Single write: m1 writes 0x1234_5678 to 0x0000_0040 → m1_gnt and mem_write at T+1 with matching addr/wdata, mem_read = 0; idle at T+2.
- Contention: both req held continuously, m0 granted first → grants alternate m0, m1, m0, m1; no master is granted twice in a row.
- Latency sweep, RD_LATENCY = 3: read at T → rvalid at T+5. rdata equals the mem_rdata presented at T+4, not values at T+2 or T+3.
- Reset mid-read: assert rst during ARB_WAIT → no rvalid. After release, a new m1 read completes normally with rdata = new memory value.
